// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS-subset pipeline.
// Opcodes, funct codes, ALU encodings and inter-stage bundles.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src_imm;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       illegal;
    logic       uses_rt;
    logic       rd_is_rd;
    logic       rd_is_rt;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        illegal;
  } id_ex_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode/funct decoder.
// Produces control flags, ALU op, destination select and rt usage.
module control_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        ctrl.rd_is_rd  = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.uses_rt   = 1'b1;
        unique case (1'b1)
          (funct == F_ADD): ctrl.alu_op = ALU_ADD;
          (funct == F_SUB): ctrl.alu_op = ALU_SUB;
          (funct == F_AND): ctrl.alu_op = ALU_AND;
          (funct == F_OR):  ctrl.alu_op = ALU_OR;
          (funct == F_SLT): ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      (opcode == OP_ADDI): begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.rd_is_rt    = 1'b1;
      end
      (opcode == OP_LW): begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.rd_is_rt    = 1'b1;
      end
      (opcode == OP_SW): begin
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_write   = 1'b1;
        ctrl.uses_rt     = 1'b1;
      end
      (opcode == OP_BEQ): begin
        ctrl.alu_op  = ALU_SUB;
        ctrl.branch  = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage: decode, MEM forwarding, load-use stall, ID/EX register.
// Bubbles clear the whole ID/EX bundle, not just the control flags.
module decode_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic        if_stall,
  output logic [4:0]  rf_read_addr_0,
  output logic [4:0]  rf_read_addr_1,
  input  logic [31:0] rf_read_data_0,
  input  logic [31:0] rf_read_data_1,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_result,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic [31:0] id_ex_imm,
  output logic [3:0]  id_ex_alu_op,
  output logic        id_ex_alu_src_imm,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_reg_write,
  output logic        id_ex_branch,
  output logic        id_ex_illegal
);

  ctrl_t       ctrl;
  id_ex_t      q;
  id_ex_t      d;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd_sel;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;
  logic        hazard;

  control_decoder u_dec (
    .opcode (if_instr[31:26]),
    .funct  (if_instr[5:0]),
    .ctrl   (ctrl)
  );

  assign rs = if_instr[25:21];
  assign rt = if_instr[20:16];
  assign rf_read_addr_0 = rs;
  assign rf_read_addr_1 = rt;

  assign rd_sel = ctrl.rd_is_rd ? if_instr[15:11] :
                  ctrl.rd_is_rt ? rt : 5'd0;

  assign rs_fwd = (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs)
                  ? mem_result : rf_read_data_0;
  assign rt_fwd = (mem_reg_write && mem_rd != 5'd0 && mem_rd == rt)
                  ? mem_result : rf_read_data_1;

  // Only a load in EX can't be covered by EX-stage forwarding.
  assign hazard = if_valid && q.valid && q.mem_read &&
                  q.rd != 5'd0 &&
                  (q.rd == rs || (ctrl.uses_rt && q.rd == rt));

  assign if_stall = hazard && !flush;

  always_comb begin
    d = '0;
    if (!flush && !hazard && if_valid) begin
      d.valid       = 1'b1;
      d.pc          = if_pc;
      d.rs_data     = rs_fwd;
      d.rt_data     = rt_fwd;
      d.rs          = rs;
      d.rt          = rt;
      d.rd          = rd_sel;
      d.imm         = sext16(if_instr[15:0]);
      d.alu_op      = ctrl.alu_op;
      d.alu_src_imm = ctrl.alu_src_imm;
      d.mem_read    = ctrl.mem_read;
      d.mem_write   = ctrl.mem_write;
      d.reg_write   = ctrl.reg_write && rd_sel != 5'd0;
      d.branch      = ctrl.branch;
      d.illegal     = ctrl.illegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign id_ex_valid       = q.valid;
  assign id_ex_pc          = q.pc;
  assign id_ex_rs_data     = q.rs_data;
  assign id_ex_rt_data     = q.rt_data;
  assign id_ex_rs          = q.rs;
  assign id_ex_rt          = q.rt;
  assign id_ex_rd          = q.rd;
  assign id_ex_imm         = q.imm;
  assign id_ex_alu_op      = q.alu_op;
  assign id_ex_alu_src_imm = q.alu_src_imm;
  assign id_ex_mem_read    = q.mem_read;
  assign id_ex_mem_write   = q.mem_write;
  assign id_ex_reg_write   = q.reg_write;
  assign id_ex_branch      = q.branch;
  assign id_ex_illegal     = q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized self-checking bench for decode_stage.
// Expected values come from an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        if_stall;
  logic [4:0]  rf_read_addr_0;
  logic [4:0]  rf_read_addr_1;
  logic [31:0] rf_read_data_0;
  logic [31:0] rf_read_data_1;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_result = '0;
  logic        id_ex_valid;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic [31:0] id_ex_imm;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src_imm;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_reg_write;
  logic        id_ex_branch;
  logic        id_ex_illegal;

  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;

  // model of the ID/EX state that matters for hazards
  logic       m_valid = 1'b0;
  logic       m_mem_read = 1'b0;
  logic [4:0] m_rd = '0;

  always #5 clk = ~clk;

  assign rf_read_data_0 = (rf_read_addr_0 == 5'd0) ? 32'd0 : rf[rf_read_addr_0];
  assign rf_read_data_1 = (rf_read_addr_1 == 5'd0) ? 32'd0 : rf[rf_read_addr_1];

  decode_stage dut (
    .clk               (clk),
    .rst               (rst),
    .if_valid          (if_valid),
    .if_instr          (if_instr),
    .if_pc             (if_pc),
    .flush             (flush),
    .if_stall          (if_stall),
    .rf_read_addr_0    (rf_read_addr_0),
    .rf_read_addr_1    (rf_read_addr_1),
    .rf_read_data_0    (rf_read_data_0),
    .rf_read_data_1    (rf_read_data_1),
    .mem_reg_write     (mem_reg_write),
    .mem_rd            (mem_rd),
    .mem_result        (mem_result),
    .id_ex_valid       (id_ex_valid),
    .id_ex_pc          (id_ex_pc),
    .id_ex_rs_data     (id_ex_rs_data),
    .id_ex_rt_data     (id_ex_rt_data),
    .id_ex_rs          (id_ex_rs),
    .id_ex_rt          (id_ex_rt),
    .id_ex_rd          (id_ex_rd),
    .id_ex_imm         (id_ex_imm),
    .id_ex_alu_op      (id_ex_alu_op),
    .id_ex_alu_src_imm (id_ex_alu_src_imm),
    .id_ex_mem_read    (id_ex_mem_read),
    .id_ex_mem_write   (id_ex_mem_write),
    .id_ex_reg_write   (id_ex_reg_write),
    .id_ex_branch      (id_ex_branch),
    .id_ex_illegal     (id_ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input int s, input int t, input int d, input int fn);
    logic [31:0] w;
    w = '0;
    w[25:21] = 5'(s);
    w[20:16] = 5'(t);
    w[15:11] = 5'(d);
    w[5:0] = 6'(fn);
    return w;
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int s, input int t, input int imm);
    logic [31:0] w;
    w[31:26] = 6'(op);
    w[25:21] = 5'(s);
    w[20:16] = 5'(t);
    w[15:0] = 16'(imm);
    return w;
  endfunction

  // One ID cycle: drive at negedge, check comb outputs, clock, check ID/EX.
  task automatic step(input logic [31:0] ins, input logic v, input logic fl,
                      input logic mw, input logic [4:0] mrd, input logic [31:0] mres,
                      output logic stall_exp);
    int op, fn, rs, rt, rd, alu;
    logic legal, rtype, uses_rt, hz, load;
    logic ev, e_src, e_mr, e_mw, e_rw, e_br, e_ill;
    logic [31:0] e_rs_data, e_rt_data, e_imm;
    if_instr = ins;
    if_valid = v;
    flush = fl;
    mem_reg_write = mw;
    mem_rd = mrd;
    mem_result = mres;
    if_pc = $urandom;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    rtype = (op == 0);
    legal = (rtype && (fn == 'h20 || fn == 'h22 || fn == 'h24 || fn == 'h25 || fn == 'h2A))
         || op == 'h08 || op == 'h23 || op == 'h2B || op == 'h04;
    uses_rt = legal && (rtype || op == 'h2B || op == 'h04);
    hz = v && m_valid && m_mem_read && m_rd != 0 &&
         (int'(m_rd) == rs || (uses_rt && int'(m_rd) == rt));
    stall_exp = hz && !fl;
    #1;
    chk("if_stall", {31'd0, if_stall}, {31'd0, stall_exp});
    chk("rd_addr0", {27'd0, rf_read_addr_0}, 32'(rs));
    chk("rd_addr1", {27'd0, rf_read_addr_1}, 32'(rt));
    load = v && !fl && !hz;
    rd = !legal ? 0 : rtype ? int'(ins[15:11]) : (op == 'h08 || op == 'h23) ? rt : 0;
    alu = 0;
    if (legal && rtype)
      case (fn)
        'h22: alu = 1;
        'h24: alu = 2;
        'h25: alu = 3;
        'h2A: alu = 4;
        default: alu = 0;
      endcase
    if (legal && op == 'h04) alu = 1;
    ev = load;
    e_src = load && legal && (op == 'h08 || op == 'h23 || op == 'h2B);
    e_mr = load && legal && op == 'h23;
    e_mw = load && legal && op == 'h2B;
    e_rw = load && legal && (rtype || op == 'h08 || op == 'h23) && rd != 0;
    e_br = load && legal && op == 'h04;
    e_ill = load && !legal;
    e_rs_data = (mw && mrd != 0 && int'(mrd) == rs) ? mres : (rs == 0 ? 32'd0 : rf[rs]);
    e_rt_data = (mw && mrd != 0 && int'(mrd) == rt) ? mres : (rt == 0 ? 32'd0 : rf[rt]);
    e_imm = {{16{ins[15]}}, ins[15:0]};
    @(posedge clk);
    #1;
    m_valid = ev;
    m_mem_read = e_mr;
    m_rd = load ? 5'(rd) : 5'd0;
    chk("valid", {31'd0, id_ex_valid}, {31'd0, ev});
    chk("flags", {26'd0, id_ex_alu_src_imm, id_ex_mem_read, id_ex_mem_write,
                  id_ex_reg_write, id_ex_branch, id_ex_illegal},
                 {26'd0, e_src, e_mr, e_mw, e_rw, e_br, e_ill});
    if (ev) begin
      chk("rs_data", id_ex_rs_data, e_rs_data);
      chk("rt_data", id_ex_rt_data, e_rt_data);
      chk("rs", {27'd0, id_ex_rs}, 32'(rs));
      chk("rt", {27'd0, id_ex_rt}, 32'(rt));
      chk("rd", {27'd0, id_ex_rd}, 32'(rd));
      chk("imm", id_ex_imm, e_imm);
      chk("alu_op", {28'd0, id_ex_alu_op}, 32'(alu));
    end
    @(negedge clk);
  endtask

  logic st;
  logic [31:0] ins;
  logic held;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    #12;
    chk("rst_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("rst_pc", id_ex_pc, 32'd0);
    chk("rst_rw", {31'd0, id_ex_reg_write}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(r_ins(1, 2, 3, 'h20), 1, 0, 0, 0, 0, st);
    chk("tp_add_rs", id_ex_rs_data, 32'd5);
    chk("tp_add_rt", id_ex_rt_data, 32'd7);
    chk("tp_add_rd", {27'd0, id_ex_rd}, 32'd3);
    chk("tp_add_rw", {31'd0, id_ex_reg_write}, 32'd1);

    step(i_ins('h23, 1, 4, 8), 1, 0, 0, 0, 0, st);
    step(r_ins(4, 2, 5, 'h20), 1, 0, 0, 0, 0, st);
    chk("tp_lu_stall", {31'd0, st}, 32'd1);
    chk("tp_lu_bubble", {31'd0, id_ex_valid}, 32'd0);
    step(r_ins(4, 2, 5, 'h20), 1, 0, 1, 4, 32'h1234, st);
    chk("tp_lu_fwd", id_ex_rs_data, 32'h1234);

    step(i_ins('h2B, 1, 2, 0), 1, 0, 1, 2, 32'hAA, st);
    chk("tp_sw_fwd", id_ex_rt_data, 32'hAA);

    step(i_ins('h08, 1, 0, 1), 1, 0, 0, 0, 0, st);
    chk("tp_r0_rw", {31'd0, id_ex_reg_write}, 32'd0);
    step(r_ins(0, 0, 6, 'h20), 1, 0, 1, 0, 32'hFFFF, st);
    chk("tp_r0_nofwd", id_ex_rs_data, 32'd0);

    step(i_ins('h23, 1, 4, 8), 1, 0, 0, 0, 0, st);
    step(r_ins(4, 2, 5, 'h20), 1, 1, 0, 0, 0, st);
    chk("tp_flush_stall", {31'd0, st}, 32'd0);
    chk("tp_flush_bubble", {31'd0, id_ex_valid}, 32'd0);

    step(i_ins('h3F, 1, 2, 3), 1, 0, 0, 0, 0, st);
    chk("tp_illegal", {31'd0, id_ex_illegal}, 32'd1);

    held = 1'b0;
    ins = '0;
    for (int n = 0; n < 600; n++) begin
      int kind;
      logic fl;
      if (!held) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0, 1: ins = r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                            ($urandom_range(0, 5) == 0) ? 'h21 :
                            int'($urandom_range(0, 4)) == 0 ? 'h20 : 'h22 + 2 * $urandom_range(0, 1));
          2: ins = r_ins($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         ($urandom_range(0, 1) == 0) ? 'h25 : 'h2A);
          3: ins = i_ins('h08, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          4, 5: ins = i_ins('h23, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          6: ins = i_ins('h2B, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          7: ins = i_ins('h04, $urandom_range(0, 7), $urandom_range(0, 7), $urandom);
          8: ins = $urandom;
          default: ins = i_ins($urandom_range(0, 63), $urandom_range(0, 7),
                               $urandom_range(0, 7), $urandom);
        endcase
      end
      fl = ($urandom_range(0, 9) == 0);
      for (int k = 1; k < 8; k++) rf[k] = ($urandom_range(0, 3) == 0) ? $urandom : rf[k];
      step(ins, held || ($urandom_range(0, 9) != 0), fl,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, st);
      held = st;
    end

    step(r_ins(1, 2, 3, 'h20), 1, 0, 0, 0, 0, st);
    step(i_ins('h23, 1, 4, 8), 1, 0, 0, 0, 0, st);
    if_instr = r_ins(4, 2, 5, 'h20);
    if_valid = 1'b1;
    flush = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", {31'd0, id_ex_valid}, 32'd0);
    chk("async_mr", {31'd0, id_ex_mem_read}, 32'd0);
    chk("async_stall", {31'd0, if_stall}, 32'd0);
    m_valid = 1'b0;
    m_mem_read = 1'b0;
    m_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    step(r_ins(4, 2, 5, 'h20), 1, 0, 0, 0, 0, st);
    chk("post_rst_go", {31'd0, id_ex_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode pipeline stage of the 5-stage 32-bit MIPS-subset CPU. Accepts one instruction per cycle from fetch, drives the two combinational read ports of the register file, and forwards MEM-stage results. It detects load-use hazards and stalls fetch by inserting a bubble. It registers the decoded control and operand fields into the ID/EX pipeline register that feeds the execute stage.

## Interface
- No parameters; data width fixed at 32, register index width 5.
- clk  in  1  single clock; ID/EX register updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  `if_instr`/`if_pc` hold a real instruction.
- if_instr  in  32  instruction word from the IF/ID register.
- if_pc  in  32  PC of `if_instr`.
- flush  in  1  branch/jump redirect; kill the instruction currently in ID.
- if_stall  out  1  combinational; fetch must hold IF/ID this cycle.
- rf_read_addr_0, rf_read_addr_1  out  5  combinational; equal to rs (`instr[25:21]`) and rt (`instr[20:16]`).
- rf_read_data_0, rf_read_data_1  in  32  combinational register-file read data (r0 reads 0).
- mem_reg_write  in  1  the MEM-stage instruction writes a register.
- mem_rd  in  5  MEM-stage destination register.
- mem_result  in  32  MEM-stage ALU result.
- id_ex_valid  out  1  the ID/EX register holds a real instruction.
- id_ex_pc  out  32  PC of the registered instruction.
- id_ex_rs_data, id_ex_rt_data  out  32  operands after MEM forwarding.
- id_ex_rs, id_ex_rt, id_ex_rd  out  5  register indices, used by downstream forwarding.
- id_ex_imm  out  32  sign-extended `instr[15:0]`.
- id_ex_alu_op  out  4  ALU operation code.
- id_ex_alu_src_imm, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_branch  out  1 each  control flags.
- id_ex_illegal  out  1  opcode or funct is not supported.

## Operation
- Supported instructions:
  - R-type (opcode 0x00) with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04.
- Destination register and write enable:
  - R-type: rd = `instr[15:11]`, reg_write = 1.
  - ADDI and LW: rd = `instr[20:16]`, reg_write = 1.
  - SW and BEQ: rd = 0, reg_write = 0.
- rt counts as a source register for R-type, SW and BEQ only.
- Writes to r0:
  - Any computed rd of 0 forces reg_write to 0.
  - r0 is never forwarded and never causes a hazard.
- MEM forwarding: if `mem_reg_write && mem_rd != 0 && mem_rd == rs`, the rs operand is `mem_result`; otherwise it is `rf_read_data_0`. The rt operand uses the same rule.
- WB stage:
  - No forwarding path is needed. The register file writes on negedge, so same-cycle WB data is already visible by the following posedge.
  - The EX-stage result is not forwarded here. The execute stage forwards it using `id_ex_rs`/`id_ex_rt`.
- Load-use hazard: `id_ex_valid && id_ex_mem_read && id_ex_rd != 0`, and id_ex_rd equals rs, or equals rt when rt is a source.
  - Gated by `if_valid`.
  - On a hazard: `if_stall` = 1, and next posedge loads a bubble (`id_ex_valid` = 0, all control flags 0).
- Illegal opcode or funct: the instruction is registered with `id_ex_illegal` = 1, `id_ex_valid` = 1, and all other control flags 0.
- Priority at each posedge:
  - rst.
  - Otherwise `flush`: load a bubble; `if_stall` is forced to 0.
  - Otherwise hazard: load a bubble.
  - Otherwise `!if_valid`: load a bubble.
  - Otherwise load the decoded instruction.

## Timing
- Latency: the instruction is present at the ID inputs in cycle N and appears on the `id_ex_*` outputs after the posedge ending cycle N.
- Throughput: one instruction per cycle when no hazard is present.
- A load-use stall lasts exactly one cycle. In the next cycle `id_ex_mem_read` is 0, so the hazard clears and the held instruction decodes, taking the loaded value from MEM forwarding.
- `rf_read_addr_*` and `if_stall` are combinational from `if_instr` and the ID/EX state. There is no combinational path from `mem_result` to `if_stall`.
- Reset: all `id_ex_*` outputs go to 0 immediately and asynchronously, including `id_ex_valid` = 0. Reset asserted mid-stall discards the held state.
- Flush and hazard in the same cycle: flush wins and `if_stall` = 0.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ;
  - funct constants;
  - 4-bit ALU op encodings: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SLT=4.
- Sub-module `control_decoder`: purely combinational. Maps opcode/funct to the control flags, alu_op, rd selection, uses_rt and illegal.
- `decode_stage` contains the hazard logic, the forwarding muxes and the ID/EX register.

## Test plan
- Reset then ADD r3,r1,r2 with rf r1=5, r2=7 → next cycle `id_ex_valid`=1, rs_data=5, rt_data=7, rd=3, alu_op=ALU_ADD, reg_write=1.
- LW r4,8(r1) followed by ADD r5,r4,r2:
  - `if_stall`=1 for one cycle, one bubble is inserted;
  - then ADD registers with `mem_result`=0x1234 forwarded as rs_data (mem_rd=4).
- MEM forwarding: mem_reg_write=1, mem_rd=2, mem_result=0xAA, while SW r2,0(r1) is in ID → `id_ex_rt_data`=0xAA and `rf_read_data_1` is ignored.
- ADDI r0,r1,1 → reg_write=0. A following instruction with mem_rd=0 never forwards.
- Flush asserted during a load-use hazard → `if_stall`=0 and a bubble is loaded next cycle.
- Opcode 0x3F → `id_ex_illegal`=1 with all other control flags 0. Asynchronous rst mid-stream → `id_ex_valid`=0 with no clock edge.
